key_repeat: RTL and testbench
=============================

KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 The block SHALL have parameter DAS_DELAY, default 10, giving the frames between the initial press event and the first auto-repeat event (legal range 1..63).
REQ-002 The block SHALL have parameter ARR_PERIOD, default 3, giving the frames between successive auto-repeat events (legal range 1..63).
REQ-003 The block SHALL have port frame_clk  input  1  sole clock, one rising edge per video frame.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port keycode_in  input  8  raw USB keycode, with 8'h00 meaning no key.
REQ-006 The block SHALL have port keycode_out  output  8  one-frame move command for the piece-motion stage, with 8'h00 meaning no command.
REQ-007 The block SHALL have port key_valid  output  1  high exactly in frames where keycode_out is non-zero.
REQ-008 The block SHALL have port held  output  1  high whenever the state is not IDLE.

Function
REQ-009 All outputs SHALL be registered; keycode_in is sampled on each frame_clk rising edge, and any resulting event is visible from that edge until the next edge.
REQ-010 The block SHALL hold state IDLE, HELD, DELAY or REPEAT, plus an 8-bit last_key register and a 6-bit frame counter cnt.
REQ-011 Repeatable keys SHALL be 8'h04 (left), 8'h07 (right) and 8'h16 (down); every other non-zero code SHALL be one-shot, including 8'h1A (rotate) and 8'h19 (restart).
REQ-012 A sample of 8'h00 in any state SHALL cause next state IDLE, emit no event and clear last_key.
REQ-013 A non-zero sample that differs from last_key, in any state, SHALL emit that code for one frame and load last_key.
REQ-014 On that same edge, cnt SHALL be cleared and next state SHALL be DELAY for a repeatable key or HELD for a one-shot key.
REQ-015 In HELD, a sample equal to last_key SHALL emit nothing and remain in HELD.
REQ-016 In DELAY, a sample equal to last_key SHALL increment cnt.
REQ-017 In DELAY, when the incremented cnt reaches DAS_DELAY, the block SHALL emit last_key, clear cnt and enter REPEAT, so the first repeat occurs DAS_DELAY edges after the press edge.
REQ-018 In REPEAT, a sample equal to last_key SHALL increment cnt, and on reaching ARR_PERIOD it SHALL emit last_key and clear cnt.
REQ-019 In frames with no event, keycode_out SHALL be 8'h00 and key_valid SHALL be 0.
REQ-020 cnt SHALL never exceed 63, and comparisons SHALL be made at 6-bit width.
REQ-021 A change from one non-zero key to another SHALL be handled as a new press on that edge, with no intervening 8'h00 frame required.

Reset
REQ-022 On assertion of Reset, independent of frame_clk, the block SHALL set state to IDLE, last_key to 8'h00, cnt to 0, keycode_out to 8'h00, key_valid to 0 and held to 0.
REQ-023 After Reset is released, the first edge that samples a non-zero key SHALL be treated as a new press, even when the same key was held through the reset.

Configuration
REQ-024 When macro KEY_REPEAT_AUTOREPEAT_EN is defined, the block SHALL implement auto-repeat as specified in REQ-011 to REQ-018.
REQ-025 When KEY_REPEAT_AUTOREPEAT_EN is undefined, every key SHALL be one-shot, DELAY and REPEAT SHALL be unreachable, cnt MAY be removed, and the interface and the other requirements SHALL be unchanged.

Verification
REQ-026 With the macro defined and default parameters, keycode_in=8'h04 from edge 0 through edge 20 SHALL produce events at edges 0, 10, 13, 16 and 19, and held=1 throughout.
REQ-027 keycode_in=8'h1A held for 20 edges from edge 0 SHALL produce a single event at edge 0 and state HELD afterwards.
REQ-028 8'h04 at edges 0-4 followed by 8'h07 from edge 5 SHALL produce an 8'h04 event at edge 0, an 8'h07 event at edge 5 and an 8'h07 event at edge 15.
REQ-029 8'h07 held to edge 14 (state REPEAT), Reset pulsed between edges 14 and 15, and the key still held SHALL produce all outputs 0 immediately on assertion and a new-press event at the first edge after release.
REQ-030 8'h16 held for 3 edges, 8'h00 for 1 edge, then 8'h16 again SHALL produce events at edge 0 and edge 4, and held=0 in the frame after the 8'h00 sample.
REQ-031 With the macro undefined, 8'h04 held for 20 edges SHALL produce a single event at edge 0.

Source files
------------

// File: rtl/key_repeat.sv
// Turns raw keycodes into one-frame move commands with DAS/ARR auto-repeat; all outputs are registered.
// Define KEY_REPEAT_AUTOREPEAT_EN to enable auto-repeat; otherwise every key is one-shot.
module key_repeat #(
  parameter int DAS_DELAY  = 10,
  parameter int ARR_PERIOD = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  output logic [7:0] keycode_out,
  output logic       key_valid,
  output logic       held
);

  typedef enum logic [1:0] {IDLE, HELD, DELAY, REPEAT} state_t;

  state_t     state, state_nxt;
  logic [7:0] last_key, last_key_nxt;
  logic [7:0] event_nxt;

`ifdef KEY_REPEAT_AUTOREPEAT_EN
  logic [5:0] cnt, cnt_nxt, cnt_inc;
  logic       repeatable;

  assign cnt_inc    = cnt + 6'd1;
  assign repeatable = (keycode_in == 8'h04) || (keycode_in == 8'h07) || (keycode_in == 8'h16);
`endif

  always_comb begin
    state_nxt    = state;
    last_key_nxt = last_key;
    event_nxt    = 8'h00;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
    cnt_nxt      = cnt;
`endif
    if (keycode_in == 8'h00) begin
      state_nxt    = IDLE;
      last_key_nxt = 8'h00;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
      cnt_nxt      = 6'd0;
`endif
    end else if (keycode_in != last_key) begin
      // Any different non-zero code is a fresh press, even without a release in between
      event_nxt    = keycode_in;
      last_key_nxt = keycode_in;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
      cnt_nxt      = 6'd0;
      state_nxt    = repeatable ? DELAY : HELD;
`else
      state_nxt    = HELD;
`endif
    end else begin
`ifdef KEY_REPEAT_AUTOREPEAT_EN
      case (state)
        DELAY: begin
          if (cnt_inc == 6'(DAS_DELAY)) begin
            event_nxt = last_key;
            cnt_nxt   = 6'd0;
            state_nxt = REPEAT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        REPEAT: begin
          if (cnt_inc == 6'(ARR_PERIOD)) begin
            event_nxt = last_key;
            cnt_nxt   = 6'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: ;
      endcase
`endif
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      last_key    <= 8'h00;
      keycode_out <= 8'h00;
      key_valid   <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_key    <= last_key_nxt;
      keycode_out <= event_nxt;
      key_valid   <= (event_nxt != 8'h00);
      held        <= (state_nxt != IDLE);
    end
  end

`ifdef KEY_REPEAT_AUTOREPEAT_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) cnt <= 6'd0;
    else       cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: directed frame scenarios plus randomized key holds against a press-age model.
module tb_key_repeat;

  localparam int DAS = 10;
  localparam int ARR = 3;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode_in;
  logic [7:0] keycode_out;
  logic       key_valid;
  logic       held;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: key seen last frame and edges elapsed since its press
  logic [7:0] m_prev;
  int         m_age;
  logic [7:0] m_out;
  logic       m_held;

  key_repeat #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode_in  (keycode_in),
    .keycode_out (keycode_out),
    .key_valid   (key_valid),
    .held        (held)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_rep(input logic [7:0] k);
    return (k == 8'h04) || (k == 8'h07) || (k == 8'h16);
  endfunction

  // Drive one frame's key, let the edge happen, sample 1 time unit later, advance the model
  task automatic tick(input logic [7:0] k);
    keycode_in = k;
    @(posedge frame_clk);
    #1;
    if (k == 8'h00) begin
      m_out  = 8'h00;
      m_prev = 8'h00;
    end else if (k != m_prev) begin
      m_out  = k;
      m_prev = k;
      m_age  = 0;
    end else begin
      m_age = m_age + 1;
      m_out = (AUTO && is_rep(k) && m_age >= DAS && ((m_age - DAS) % ARR) == 0) ? k : 8'h00;
    end
    m_held = (k != 8'h00);
  endtask

  // Pulse Reset between edges while keycode_in keeps its value
  task automatic pulse_reset;
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    m_prev = 8'h00;
    m_age  = 0;
  endtask

  task automatic test_reset;
    Reset      = 1'b0;
    keycode_in = 8'h00;
    #1 Reset = 1'b1;
    #2;
    n_checks++;
    if ({keycode_out, key_valid, held} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_values: out=%h valid=%b held=%b, expected 00 0 0", keycode_out, key_valid, held);
    end
    #1 Reset = 1'b0;
    m_prev = 8'h00;
    m_age  = 0;
    tick(8'h00);
    n_checks++;
    if ({keycode_out, key_valid, held} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_idle: out=%h valid=%b held=%b, expected 00 0 0", keycode_out, key_valid, held);
    end
  endtask

  task automatic test_das_arr;
    logic [7:0] exp;
    pulse_reset();
    for (int e = 0; e <= 20; e++) begin
      tick(8'h04);
      exp = (e == 0 || (AUTO && (e == 10 || e == 13 || e == 16 || e == 19))) ? 8'h04 : 8'h00;
      n_checks++;
      if ({keycode_out, key_valid, held} !== {exp, exp != 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL das_arr edge %0d: out=%h valid=%b held=%b, expected %h %b 1",
                 e, keycode_out, key_valid, held, exp, exp != 8'h00);
      end
    end
  endtask

  task automatic test_one_shot;
    logic [7:0] exp;
    tick(8'h00);
    for (int e = 0; e < 20; e++) begin
      tick(8'h1A);
      exp = (e == 0) ? 8'h1A : 8'h00;
      n_checks++;
      if ({keycode_out, key_valid, held} !== {exp, exp != 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL one_shot edge %0d: out=%h valid=%b held=%b, expected %h %b 1",
                 e, keycode_out, key_valid, held, exp, exp != 8'h00);
      end
    end
  endtask

  task automatic test_key_change;
    logic [7:0] exp;
    tick(8'h00);
    for (int e = 0; e < 20; e++) begin
      tick((e < 5) ? 8'h04 : 8'h07);
      exp = (e == 0) ? 8'h04 : (e == 5 || (AUTO && e == 15)) ? 8'h07 : 8'h00;
      n_checks++;
      if ({keycode_out, key_valid, held} !== {exp, exp != 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL key_change edge %0d: out=%h valid=%b held=%b, expected %h %b 1",
                 e, keycode_out, key_valid, held, exp, exp != 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid_repeat;
    logic [7:0] exp;
    tick(8'h00);
    for (int e = 0; e <= 14; e++) begin
      tick(8'h07);
      exp = (e == 0 || (AUTO && (e == 10 || e == 13))) ? 8'h07 : 8'h00;
      n_checks++;
      if (keycode_out !== exp) begin
        n_fail++;
        $display("FAIL reset_mid pre edge %0d: out=%h, expected %h", e, keycode_out, exp);
      end
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({keycode_out, key_valid, held} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_mid async: out=%h valid=%b held=%b, expected 00 0 0", keycode_out, key_valid, held);
    end
    #1 Reset = 1'b0;
    m_prev = 8'h00;
    m_age  = 0;
    for (int e = 15; e < 19; e++) begin
      tick(8'h07);
      exp = (e == 15) ? 8'h07 : 8'h00;
      n_checks++;
      if ({keycode_out, key_valid, held} !== {exp, exp != 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_mid post edge %0d: out=%h valid=%b held=%b, expected %h %b 1",
                 e, keycode_out, key_valid, held, exp, exp != 8'h00);
      end
    end
  endtask

  task automatic test_release;
    logic [7:0] k;
    logic [7:0] exp;
    tick(8'h00);
    for (int e = 0; e < 8; e++) begin
      k = (e == 3) ? 8'h00 : 8'h16;
      tick(k);
      exp = (e == 0 || e == 4) ? 8'h16 : 8'h00;
      n_checks++;
      if ({keycode_out, key_valid, held} !== {exp, exp != 8'h00, e != 3}) begin
        n_fail++;
        $display("FAIL release edge %0d: out=%h valid=%b held=%b, expected %h %b %b",
                 e, keycode_out, key_valid, held, exp, exp != 8'h00, e != 3);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] k;
    int         len;
    for (int h = 0; h < 60; h++) begin
      case ($urandom_range(0, 7))
        0: k = 8'h00;
        1: k = 8'h04;
        2: k = 8'h07;
        3: k = 8'h16;
        4: k = 8'h1A;
        5: k = 8'h19;
        6: k = 8'($urandom_range(1, 255));
        default: k = 8'h04;
      endcase
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        tick(k);
        n_checks++;
        if ({keycode_out, key_valid, held} !== {m_out, m_out != 8'h00, m_held}) begin
          n_fail++;
          $display("FAIL random hold %0d frame %0d key %h: out=%h valid=%b held=%b, expected %h %b %b",
                   h, i, k, keycode_out, key_valid, held, m_out, m_out != 8'h00, m_held);
        end
      end
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end
  endtask

  initial begin
    m_prev = 8'h00;
    m_age  = 0;
    m_out  = 8'h00;
    m_held = 1'b0;
    test_reset();
    test_das_arr();
    test_one_shot();
    test_key_change();
    test_reset_mid_repeat();
    test_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
